sorted_run_merger: RTL and testbench

Streaming, parametrised successor to the combinational 10-into-100 sorted insert: merges two pre-sorted runs (run A of `LEN_A` keys, run B of `LEN_B` keys) arriving on valid/ready ports into one sorted output stream, one key per cycle. Sits between the run generators and the result buffer in the sorting datapath. It removes the fixed 10/100 sizing, adds back-pressure, source tagging, input-order checking and a compile-time descending mode.

---
 rtl/sorted_run_merger.sv | 147 ++++++++++++++
 tb/tb_sorted_run_merger.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sorted_run_merger.sv
// sorted_run_merger: stable merge of two pre-sorted key runs into one valid/ready output stream.
// Define SORT_DESC_EN for descending runs; ties always go to port A.
module sorted_run_merger #(
    parameter int WIDTH = 16,
    parameter int LEN_A = 10,
    parameter int LEN_B = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_src,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             order_err
);
    localparam int CA = $clog2(LEN_A + 1);
    localparam int CB = $clog2(LEN_B + 1);
    localparam logic [CA-1:0] A_END  = CA'(LEN_A);
    localparam logic [CA-1:0] A_LAST = CA'(LEN_A - 1);
    localparam logic [CB-1:0] B_END  = CB'(LEN_B);
    localparam logic [CB-1:0] B_LAST = CB'(LEN_B - 1);

    typedef enum logic [1:0] {IDLE, MERGE, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CA-1:0]    cnt_a_q, cnt_a_d;
    logic [CB-1:0]    cnt_b_q, cnt_b_d;
    logic [WIDTH-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d, m_data_q, m_data_d;
    logic             m_src_q, m_src_d, m_last_q, m_last_d, m_valid_q, m_valid_d, err_q, err_d;
    logic             a_end, b_end, a_first, a_bad, b_bad, sel_a, sel_b, slot_free, last_a, last_b;

`ifdef SORT_DESC_EN
    assign a_first = a_data >= b_data;
    assign a_bad   = a_data > prev_a_q;
    assign b_bad   = b_data > prev_b_q;
`else
    assign a_first = a_data <= b_data;
    assign a_bad   = a_data < prev_a_q;
    assign b_bad   = b_data < prev_b_q;
`endif

    assign a_end     = cnt_a_q == A_END;
    assign b_end     = cnt_b_q == B_END;
    // Once one run is exhausted the other passes through on its own valid
    assign sel_a     = !a_end && a_valid && (b_end || (b_valid && a_first));
    assign sel_b     = !b_end && b_valid && (a_end || (a_valid && !a_first));
    assign slot_free = state_q == MERGE && (!m_valid_q || m_ready);
    assign a_ready   = slot_free && sel_a;
    assign b_ready   = slot_free && sel_b;
    assign last_a    = cnt_a_q == A_LAST && b_end;
    assign last_b    = cnt_b_q == B_LAST && a_end;

    always_comb begin
        state_d   = state_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        prev_a_d  = prev_a_q;
        prev_b_d  = prev_b_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = MERGE;
                cnt_a_d  = '0;
                cnt_b_d  = '0;
                prev_a_d = '0;
                prev_b_d = '0;
                err_d    = 1'b0;
                m_last_d = 1'b0;
            end
            MERGE: begin
                if (m_ready) m_valid_d = 1'b0;
                if (a_ready) begin
                    m_data_d  = a_data;
                    m_src_d   = 1'b0;
                    m_last_d  = last_a;
                    m_valid_d = 1'b1;
                    cnt_a_d   = cnt_a_q + 1'b1;
                    prev_a_d  = a_data;
                    err_d     = err_q || (cnt_a_q != '0 && a_bad);
                    state_d   = last_a ? FLUSH : MERGE;
                end else if (b_ready) begin
                    m_data_d  = b_data;
                    m_src_d   = 1'b1;
                    m_last_d  = last_b;
                    m_valid_d = 1'b1;
                    cnt_b_d   = cnt_b_q + 1'b1;
                    prev_b_d  = b_data;
                    err_d     = err_q || (cnt_b_q != '0 && b_bad);
                    state_d   = last_b ? FLUSH : MERGE;
                end
            end
            FLUSH: if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            m_data_q  <= '0;
            m_src_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            prev_a_q  <= prev_a_d;
            prev_b_q  <= prev_b_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_src     = m_src_q;
    assign m_last    = m_last_q;
    assign m_valid   = m_valid_q;
    assign order_err = err_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_sorted_run_merger.sv
// tb_sorted_run_merger: table-driven jobs on a 3+4 key merger with a scoreboard of expected beats.
// Follows SORT_DESC_EN so the same bench covers both sort directions.
module tb_sorted_run_merger;
    logic        clk = 1'b0;
    logic        rst_n, start, a_valid, a_ready, b_valid, b_ready;
    logic        m_src, m_last, m_valid, m_ready, busy, done, order_err;
    logic [15:0] a_data, b_data, m_data;

    always #5 clk = ~clk;

    sorted_run_merger #(.WIDTH(16), .LEN_A(3), .LEN_B(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .m_data(m_data), .m_src(m_src), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .order_err(order_err)
    );

    typedef struct packed {
        logic [0:2][15:0] a;
        logic [0:3][15:0] b;
        logic             stall;
        logic [0:6][15:0] exp_d;
        logic [0:6]       exp_s;
        logic             exp_err;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        l;
    } beat_t;

    vec_t  vecs[4];
    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    logic  err_exp = 1'b0;

    function automatic vec_t mk(logic [0:2][15:0] a, logic [0:3][15:0] b, logic st,
                                logic [0:6][15:0] d, logic [0:6] s, logic e);
        mk.a = a;
        mk.b = b;
        mk.stall = st;
        mk.exp_d = d;
        mk.exp_s = s;
        mk.exp_err = e;
    endfunction

    function automatic logic bad(logic [15:0] cur, logic [15:0] prev);
`ifdef SORT_DESC_EN
        return cur > prev;
`else
        return cur < prev;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ready"}, {30'd0, a_ready, b_ready}, 0);
        chk({tag, "_mout"}, {14'd0, m_data, m_src, m_last}, 0);
        chk({tag, "_flags"}, {28'd0, m_valid, busy, done, order_err}, 0);
    endtask

    task automatic run_job(input vec_t v, input int abort_at);
        int          ia = 0, ib = 0, nbeats = 0, hs_cyc = -100;
        bit          held = 0, fin = 0;
        logic [15:0] hd = '0;
        logic        hsrc = 0, hl = 0;
        beat_t       e;
        for (int i = 0; i < 7; i++) sb.push_back(beat_t'({v.exp_d[i], v.exp_s[i], i == 6}));
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            start   = (c == 0);
            a_data  = ia < 3 ? v.a[ia] : 16'hEEEE;
            b_data  = ib < 4 ? v.b[ib] : 16'hEEEE;
            a_valid = 1'b1;
            b_valid = 1'b1;
            m_ready = v.stall ? (c % 2 == 0) : 1'b1;
            #1;
            chk("order_err", {31'd0, order_err}, {31'd0, err_exp});
            if (c <= 1) chk("busy_rise", {31'd0, busy}, c);
            if (held) chk("hold_beat", {13'd0, m_valid, m_data, m_src, m_last}, {13'd0, 1'b1, hd, hsrc, hl});
            if (a_ready || b_ready) chk("one_ready", {31'd0, a_ready & b_ready}, 0);
            if (m_valid && !m_ready) chk("stall_ready", {31'd0, a_ready | b_ready}, 0);
            if (a_ready && ia >= 3) chk("a_after_run", 1, 0);
            if (b_ready && ib >= 4) chk("b_after_run", 1, 0);
            if (done) begin
                chk("done_time", c, hs_cyc + 1);
                if (!v.stall) chk("job_len", c, 9);
                chk("sb_empty", sb.size(), 0);
                chk("err_final", {31'd0, order_err}, {31'd0, v.exp_err});
                fin = 1;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("beat", {14'd0, m_data, m_src, m_last}, {14'd0, e});
                    nbeats++;
                    if (e.l) hs_cyc = c;
                end
            end
            held = m_valid && !m_ready;
            hd   = m_data;
            hsrc = m_src;
            hl   = m_last;
            if (c == 0) err_exp = 1'b0;
            if (a_ready && ia < 3) begin
                if (ia > 0 && bad(v.a[ia], v.a[ia-1])) err_exp = 1'b1;
                ia++;
            end
            if (b_ready && ib < 4) begin
                if (ib > 0 && bad(v.b[ib], v.b[ib-1])) err_exp = 1'b1;
                ib++;
            end
            if (abort_at > 0 && nbeats == abort_at) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst_n = 1'b1;
                sb.delete();
                err_exp = 1'b0;
                fin = 1;
            end
        end
        chk("timeout", {31'd0, fin}, 1);
        if (abort_at == 0) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("done_pulse", {30'd0, done, busy}, 0);
        end
    endtask

    initial begin
`ifdef SORT_DESC_EN
        vecs[0] = mk({16'd9, 16'd5, 16'd2}, {16'd10, 16'd6, 16'd5, 16'd1}, 1'b0,
                     {16'd10, 16'd9, 16'd6, 16'd5, 16'd5, 16'd2, 16'd1}, 7'b1010101, 1'b0);
        vecs[1] = vecs[0];
        vecs[1].stall = 1'b1;
        vecs[2] = mk({16'd3, 16'd2, 16'd1}, {16'd9, 16'd9, 16'd8, 16'd7}, 1'b0,
                     {16'd9, 16'd9, 16'd8, 16'd7, 16'd3, 16'd2, 16'd1}, 7'b1111000, 1'b0);
        vecs[3] = mk({16'd5, 16'd6, 16'd1}, {16'd10, 16'd6, 16'd5, 16'd1}, 1'b0,
                     {16'd10, 16'd6, 16'd5, 16'd6, 16'd5, 16'd1, 16'd1}, 7'b1100101, 1'b1);
`else
        vecs[0] = mk({16'd2, 16'd5, 16'd9}, {16'd1, 16'd5, 16'd6, 16'd10}, 1'b0,
                     {16'd1, 16'd2, 16'd5, 16'd5, 16'd6, 16'd9, 16'd10}, 7'b1001101, 1'b0);
        vecs[1] = vecs[0];
        vecs[1].stall = 1'b1;
        vecs[2] = mk({16'd1, 16'd2, 16'd3}, {16'd7, 16'd8, 16'd9, 16'd9}, 1'b0,
                     {16'd1, 16'd2, 16'd3, 16'd7, 16'd8, 16'd9, 16'd9}, 7'b0001111, 1'b0);
        vecs[3] = mk({16'd4, 16'd3, 16'd8}, {16'd1, 16'd5, 16'd6, 16'd10}, 1'b0,
                     {16'd1, 16'd4, 16'd3, 16'd5, 16'd6, 16'd8, 16'd10}, 7'b1001101, 1'b1);
`endif
        rst_n   = 1'b0;
        start   = 1'b0;
        a_data  = '0;
        b_data  = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) run_job(vecs[i], 0);
        run_job(vecs[0], 3);
        run_job(vecs[0], 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
